// File: rtl/vinc_pkg.sv
// Shared types for the vector inc register file write-back path.
package vinc_pkg;

    localparam int unsigned DefWidth       = 32;
    localparam int unsigned DefLog2NumRegs = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StInit = 2'd1,
        StRun  = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [DefLog2NumRegs-1:0] regnum;
        logic [DefWidth-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/vinc_wbfifo.sv
// Write-buffer FIFO for inc register writes; exposes per-slot valid and target
// register so the parent can build the pending mask.
module vinc_wbfifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned RegW  = 3,
    parameter int unsigned Depth = 4,
    parameter int unsigned AddrW = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [RegW-1:0]       push_reg,
    input  logic [Width-1:0]      push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [RegW-1:0]       head_reg,
    output logic [Width-1:0]      head_data,
    output logic [Depth-1:0]      entry_valid,
    output logic [Depth*RegW-1:0] entry_regs
);

    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]   count_q, count_d;
    logic [RegW-1:0]  reg_q  [Depth];
    logic [Width-1:0] data_q [Depth];

    logic do_push;
    logic do_pop;

    assign full  = (count_q == (AddrW+1)'(Depth));
    assign empty = (count_q == '0);

    // Occupancy is sampled at the start of the cycle; a same-cycle pop never frees a slot.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_reg  = reg_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AddrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AddrW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AddrW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AddrW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; validity comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            reg_q[wr_ptr_q]  <= push_reg;
            data_q[wr_ptr_q] <= push_data;
        end
    end

    always_comb begin
        logic [AddrW-1:0] off;
        entry_valid = '0;
        entry_regs  = '0;
        for (int k = 0; k < Depth; k++) begin
            off            = AddrW'(k) - rd_ptr_q;
            entry_valid[k] = ({1'b0, off} < count_q);
            entry_regs[k*RegW +: RegW] = reg_q[k];
        end
    end

endmodule

// File: rtl/vinc_writeback.sv
// Write-side controller for the vector inc register file: post-reset clear sweep,
// scalar/memory-unit arbitration, buffered single-port write-back and pending mask.
module vinc_writeback
    import vinc_pkg::*;
#(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned NUMREGS       = 8,
    parameter int unsigned LOG2NUMREGS   = 3,
    parameter int unsigned FIFODEPTH     = 4,
    parameter int unsigned LOG2FIFODEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    input  logic [LOG2NUMREGS-1:0] s_reg,
    input  logic [WIDTH-1:0]       s_data,
    output logic                   s_ready,
    input  logic                   m_valid,
    input  logic [LOG2NUMREGS-1:0] m_reg,
    input  logic [WIDTH-1:0]       m_data,
    output logic                   m_ready,
    output logic [LOG2NUMREGS-1:0] c_reg,
    output logic [WIDTH-1:0]       c_writedatain,
    output logic                   c_we,
    output logic [NUMREGS-1:0]     pending,
    output logic                   init_done
);

    wb_state_e state_q, state_d;
    logic [LOG2NUMREGS-1:0] sweep_q, sweep_d;

    logic                             fifo_push;
    logic [LOG2NUMREGS-1:0]           fifo_push_reg;
    logic [WIDTH-1:0]                 fifo_push_data;
    logic                             fifo_pop;
    logic                             fifo_full;
    logic                             fifo_empty;
    logic [LOG2NUMREGS-1:0]           head_reg;
    logic [WIDTH-1:0]                 head_data;
    logic [FIFODEPTH-1:0]             entry_valid;
    logic [FIFODEPTH*LOG2NUMREGS-1:0] entry_regs;

    logic sweep_last;
    assign sweep_last = (sweep_q == LOG2NUMREGS'(NUMREGS - 1));

    always_comb begin
        state_d        = state_q;
        sweep_d        = sweep_q;
        s_ready        = 1'b0;
        m_ready        = 1'b0;
        c_we           = 1'b0;
        c_reg          = '0;
        c_writedatain  = '0;
        fifo_push      = 1'b0;
        fifo_push_reg  = s_reg;
        fifo_push_data = s_data;
        fifo_pop       = 1'b0;
        init_done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                state_d = StInit;
            end
            StInit: begin
                c_we  = 1'b1;
                c_reg = sweep_q;
                if (sweep_last) begin
                    state_d = StRun;
                end else begin
                    sweep_d = sweep_q + LOG2NUMREGS'(1);
                end
            end
            StRun: begin
                init_done = 1'b1;
                // Scalar path has fixed priority over the memory unit.
                s_ready   = !fifo_full;
                m_ready   = !fifo_full && !s_valid;
                if (s_valid && s_ready) begin
                    fifo_push = (s_reg != '0);
                end else if (m_valid && m_ready) begin
                    fifo_push      = (m_reg != '0);
                    fifo_push_reg  = m_reg;
                    fifo_push_data = m_data;
                end
                if (!fifo_empty) begin
                    c_we          = 1'b1;
                    c_reg         = head_reg;
                    c_writedatain = head_data;
                    fifo_pop      = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            sweep_q <= LOG2NUMREGS'(1);
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    vinc_wbfifo #(
        .Width (WIDTH),
        .RegW  (LOG2NUMREGS),
        .Depth (FIFODEPTH),
        .AddrW (LOG2FIFODEPTH)
    ) u_wbfifo (
        .clk         (clk),
        .reset       (reset),
        .push        (fifo_push),
        .push_reg    (fifo_push_reg),
        .push_data   (fifo_push_data),
        .pop         (fifo_pop),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head_reg    (head_reg),
        .head_data   (head_data),
        .entry_valid (entry_valid),
        .entry_regs  (entry_regs)
    );

    // Register 0 is never enqueued, so pending[0] stays clear.
    always_comb begin
        pending = '0;
        for (int i = 1; i < NUMREGS; i++) begin
            for (int k = 0; k < FIFODEPTH; k++) begin
                if (entry_valid[k] &&
                    entry_regs[k*LOG2NUMREGS +: LOG2NUMREGS] == LOG2NUMREGS'(i)) begin
                    pending[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vinc_writeback.sv
// Directed self-checking bench for vinc_writeback with a small register-file model.
module tb_vinc_writeback;

    logic        clk;
    logic        reset;
    logic        s_valid;
    logic [2:0]  s_reg;
    logic [31:0] s_data;
    logic        s_ready;
    logic        m_valid;
    logic [2:0]  m_reg;
    logic [31:0] m_data;
    logic        m_ready;
    logic [2:0]  c_reg;
    logic [31:0] c_writedatain;
    logic        c_we;
    logic [7:0]  pending;
    logic        init_done;

    int unsigned checks;
    int unsigned errors;
    logic [31:0] rf [8];

    vinc_writeback dut (
        .clk           (clk),
        .reset         (reset),
        .s_valid       (s_valid),
        .s_reg         (s_reg),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .m_valid       (m_valid),
        .m_reg         (m_reg),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .c_reg         (c_reg),
        .c_writedatain (c_writedatain),
        .c_we          (c_we),
        .pending       (pending),
        .init_done     (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: commits on the edge where c_we is high.
    always @(posedge clk) begin
        if (c_we) rf[c_reg] <= c_writedatain;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at the negedge where reset was just released.
    task automatic run_sweep();
        #1;
        check_eq("idle_we", {31'b0, c_we}, 32'd0);
        check_eq("idle_sready", {31'b0, s_ready}, 32'd0);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            check_eq($sformatf("sweep_we_%0d", k), {31'b0, c_we}, 32'd1);
            check_eq($sformatf("sweep_reg_%0d", k), {29'b0, c_reg}, k);
            check_eq($sformatf("sweep_data_%0d", k), c_writedatain, 32'd0);
            check_eq($sformatf("sweep_rdy_%0d", k), {30'b0, s_ready, m_ready}, 32'd0);
            check_eq($sformatf("sweep_done_%0d", k), {31'b0, init_done}, 32'd0);
        end
        @(negedge clk);
        check_eq("init_done", {31'b0, init_done}, 32'd1);
        check_eq("post_sweep_we", {31'b0, c_we}, 32'd0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_reg   = '0;
        s_data  = '0;
        m_valid = 1'b0;
        m_reg   = '0;
        m_data  = '0;
        for (int i = 0; i < 8; i++) rf[i] = 32'hFFFF_FFFF;

        repeat (2) @(negedge clk);
        check_eq("rst_we", {31'b0, c_we}, 32'd0);
        check_eq("rst_reg", {29'b0, c_reg}, 32'd0);
        check_eq("rst_data", c_writedatain, 32'd0);
        check_eq("rst_rdy", {30'b0, s_ready, m_ready}, 32'd0);
        check_eq("rst_pending", {24'b0, pending}, 32'd0);
        check_eq("rst_done", {31'b0, init_done}, 32'd0);
        reset = 1'b0;
        run_sweep();
        check_eq("rf3_cleared", rf[3], 32'd0);

        // Both requesters at once: scalar wins.
        s_valid = 1'b1; s_reg = 3'd3; s_data = 32'h33;
        m_valid = 1'b1; m_reg = 3'd5; m_data = 32'h55;
        #1;
        check_eq("arb_sready", {31'b0, s_ready}, 32'd1);
        check_eq("arb_mready", {31'b0, m_ready}, 32'd0);
        @(negedge clk);
        check_eq("arb_c_reg3", {29'b0, c_reg}, 32'd3);
        check_eq("arb_c_data3", c_writedatain, 32'h33);
        check_eq("arb_pend3", {24'b0, pending}, 32'h08);
        s_valid = 1'b0;
        #1;
        check_eq("arb_mready2", {31'b0, m_ready}, 32'd1);
        @(negedge clk);
        check_eq("arb_c_reg5", {29'b0, c_reg}, 32'd5);
        check_eq("arb_c_data5", c_writedatain, 32'h55);
        check_eq("arb_pend5", {24'b0, pending}, 32'h20);
        m_valid = 1'b0;
        @(negedge clk);
        check_eq("arb_idle_we", {31'b0, c_we}, 32'd0);
        check_eq("arb_idle_pend", {24'b0, pending}, 32'd0);
        check_eq("rf3", rf[3], 32'h33);
        check_eq("rf5", rf[5], 32'h55);

        // Six back-to-back scalar writes.
        for (int i = 1; i <= 6; i++) begin
            if (i > 1) begin
                check_eq($sformatf("b2b_we_%0d", i - 1), {31'b0, c_we}, 32'd1);
                check_eq($sformatf("b2b_reg_%0d", i - 1), {29'b0, c_reg}, i - 1);
                check_eq($sformatf("b2b_data_%0d", i - 1), c_writedatain, 32'h100 + i - 1);
            end
            s_valid = 1'b1; s_reg = 3'(i); s_data = 32'h100 + i;
            #1;
            check_eq($sformatf("b2b_sready_%0d", i), {31'b0, s_ready}, 32'd1);
            @(negedge clk);
        end
        check_eq("b2b_reg_6", {29'b0, c_reg}, 32'd6);
        check_eq("b2b_data_6", c_writedatain, 32'h106);
        s_valid = 1'b0;
        @(negedge clk);
        check_eq("b2b_drained", {31'b0, c_we}, 32'd0);
        check_eq("rf6", rf[6], 32'h106);

        // Register 0 writes are swallowed.
        s_valid = 1'b1; s_reg = 3'd0; s_data = 32'hDEAD_BEEF;
        #1;
        check_eq("r0_sready", {31'b0, s_ready}, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        check_eq("r0_we", {31'b0, c_we}, 32'd0);
        check_eq("r0_pending", {24'b0, pending}, 32'd0);

        // Duplicate target: last write wins, pending held through both.
        s_valid = 1'b1; s_reg = 3'd2; s_data = 32'h11;
        @(negedge clk);
        check_eq("dup_pend_a", {24'b0, pending}, 32'h04);
        check_eq("dup_data_a", c_writedatain, 32'h11);
        s_data = 32'h22;
        @(negedge clk);
        s_valid = 1'b0;
        check_eq("dup_pend_b", {24'b0, pending}, 32'h04);
        check_eq("dup_data_b", c_writedatain, 32'h22);
        @(negedge clk);
        check_eq("dup_pend_clr", {24'b0, pending}, 32'd0);
        check_eq("rf2", rf[2], 32'h22);

        // Reset with a write still buffered.
        for (int i = 4; i <= 6; i++) begin
            s_valid = 1'b1; s_reg = 3'(i); s_data = 32'h40 + i;
            @(negedge clk);
        end
        s_valid = 1'b0;
        check_eq("mid_pend", {24'b0, pending}, 32'h40);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_we", {31'b0, c_we}, 32'd0);
        check_eq("mid_rst_pend", {24'b0, pending}, 32'd0);
        check_eq("mid_rst_done", {31'b0, init_done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_sweep();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("no_stale_%0d", i), {31'b0, c_we}, 32'd0);
        end
        check_eq("rf4_swept", rf[4], 32'd0);
        check_eq("rf6_swept", rf[6], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
